// File: rtl/or4_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or4_seq_pkg
// Description : Shared types and constants for the 4-input OR stimulus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package or4_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int ERR_W       = 5;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    // Golden response of the OR gate under test for a given vector.
    function automatic logic or_expected(input logic [VEC_W-1:0] vec);
        return |vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/or4_hold_timer_v.sv
`default_nettype none
// ============================================================================
// Module      : or4_hold_timer_v
// Description : Free-running 0..HOLD_CYCLES-1 counter with synchronous clear
//               and terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module or4_hold_timer_v
    import or4_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tc
);

    localparam int                CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  c_TC  = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == c_TC);
    assign o_tc = w_tc;

    // Wraps to zero on its own at terminal count so the next vector starts fresh.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/or4_stim_seq_v.sv
`default_nettype none
// ============================================================================
// Module      : or4_stim_seq_v
// Description : Walks all 16 input vectors through a 4-input OR under test,
//               holding each for HOLD_CYCLES and counting response mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module or4_stim_seq_v
    import or4_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_f,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c,
    output logic             o_d,
    output logic             o_busy,
    output logic             o_done,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_pass
);

    state_t           r_state;
    state_t           w_state_next;
    logic [VEC_W-1:0] r_idx;
    logic [VEC_W-1:0] w_idx_next;
    logic [VEC_W-1:0] r_vec;
    logic [ERR_W-1:0] r_err_cnt;
    logic [ERR_W-1:0] w_err_next;
    logic             r_pass;
    logic             w_pass_next;
    logic             r_busy;
    logic             r_done;
    logic             w_tc;
    logic             w_timer_clr;

    assign w_timer_clr = (r_state != RUN);

    or4_hold_timer_v #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_timer_clr),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err_next   = r_err_cnt;
        w_pass_next  = r_pass;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = RUN;
                    w_idx_next   = '0;
                    w_err_next   = '0;
                    w_pass_next  = 1'b0;
                end
            end
            RUN: begin
                if (w_tc) begin
                    if (i_f != or_expected(r_idx)) begin
                        w_err_next = r_err_cnt + ERR_W'(1);
                    end
                    if (r_idx == LAST_VEC) begin
                        w_state_next = DONE;
                        w_idx_next   = '0;
                        w_pass_next  = (w_err_next == '0);
                    end else begin
                        w_idx_next = r_idx + VEC_W'(1);
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_vec     <= '0;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_vec     <= (w_state_next == RUN) ? w_idx_next : '0;
            r_err_cnt <= w_err_next;
            r_pass    <= w_pass_next;
            r_busy    <= (w_state_next == RUN);
            r_done    <= (w_state_next == DONE);
        end
    end

    assign o_a       = r_vec[3];
    assign o_b       = r_vec[2];
    assign o_c       = r_vec[1];
    assign o_d       = r_vec[0];
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err_cnt = r_err_cnt;
    assign o_pass    = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_or4_stim_seq_v.sv
`default_nettype none
// ============================================================================
// Module      : tb_or4_stim_seq_v
// Description : Scoreboard bench for or4_stim_seq_v with a fault-injecting OR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or4_stim_seq_v;

    localparam int HOLD    = 4;
    localparam int RUN_LEN = 16 * HOLD;

    typedef struct {
        int start;
        int err;
        int pass;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_f;
    logic       o_a, o_b, o_c, o_d;
    logic       o_busy, o_done, o_pass;
    logic [4:0] o_err_cnt;
    logic [15:0] r_mask;
    logic [3:0]  w_vec;

    exp_t q[$];
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   m_busy;
    int   m_vec;
    logic prev_done;

    or4_stim_seq_v #(
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (i_start),
        .i_f       (i_f),
        .o_a       (o_a),
        .o_b       (o_b),
        .o_c       (o_c),
        .o_d       (o_d),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err_cnt (o_err_cnt),
        .o_pass    (o_pass)
    );

    // Downstream OR gate: a set bit in r_mask inverts its answer for that vector.
    assign w_vec = {o_a, o_b, o_c, o_d};
    assign i_f   = (|w_vec) ^ r_mask[w_vec];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle run window check plus completion scoreboard.
    always @(negedge clk) begin
        m_busy = 0;
        m_vec  = 0;
        if (q.size() > 0 && cyc >= q[0].start && cyc < q[0].start + RUN_LEN) begin
            m_busy = 1;
            m_vec  = (cyc - q[0].start) / HOLD;
        end
        chk("busy", int'(o_busy), m_busy);
        chk("vector", int'(w_vec), m_vec);
        if (o_done) begin
            chk("done_consecutive", int'(prev_done), 0);
            if (q.size() == 0) begin
                chk("unexpected_done", int'(o_done), 0);
            end else begin
                exp_t it;
                it = q.pop_front();
                chk("done_cycle", cyc, it.start + RUN_LEN);
                chk("err_cnt", int'(o_err_cnt), it.err);
                chk("pass", int'(o_pass), it.pass);
            end
        end else if (q.size() > 0 && cyc == q[0].start + RUN_LEN) begin
            chk("done_missing", int'(o_done), 1);
        end
        prev_done = o_done;
    end

    task automatic issue_start(input logic [15:0] mask, output int start_edge);
        exp_t it;
        int   errs;
        r_mask = mask;
        @(negedge clk);
        errs       = $countones(mask);
        start_edge = cyc + 1;
        it.start   = start_edge;
        it.err     = errs;
        it.pass    = (errs == 0) ? 1 : 0;
        q.push_back(it);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("err_cleared_on_start", int'(o_err_cnt), 0);
        chk("pass_cleared_on_start", int'(o_pass), 0);
    endtask

    task automatic run_test(input logic [15:0] mask, input bit extra_starts);
        int e;
        int errs;
        issue_start(mask, e);
        errs = $countones(mask);
        if (extra_starts) begin
            while (cyc < e + 10) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            while (cyc < e + RUN_LEN) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end
        for (int k = 0; k < 3 * RUN_LEN && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 0);
            q.delete();
        end
        repeat (5) @(negedge clk);
        chk("err_hold_idle", int'(o_err_cnt), errs);
        chk("pass_hold_idle", int'(o_pass), (errs == 0) ? 1 : 0);
    endtask

    initial begin
        int e;
        n_chk     = 0;
        n_fail    = 0;
        prev_done = 1'b0;
        r_mask    = '0;
        i_start   = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("reset_vec", int'(w_vec), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_err", int'(o_err_cnt), 0);
        chk("reset_pass", int'(o_pass), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test(16'h0000, 1'b0);
        run_test(16'hFFFE, 1'b0);
        run_test(16'h0001, 1'b0);
        run_test(16'h0000, 1'b1);
        run_test(16'hFFFE, 1'b0);
        run_test(16'h0000, 1'b0);

        // Abort a run while vector 0101 is on the outputs.
        issue_start(16'h0000, e);
        for (int k = 0; k < 3 * RUN_LEN && w_vec != 4'b0101; k++) @(negedge clk);
        chk("reach_0101", int'(w_vec), 5);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst_vec", int'(w_vec), 0);
        chk("async_rst_busy", int'(o_busy), 0);
        chk("async_rst_done", int'(o_done), 0);
        chk("async_rst_err", int'(o_err_cnt), 0);
        chk("async_rst_pass", int'(o_pass), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (RUN_LEN + 4) @(negedge clk);
        run_test(16'h0000, 1'b0);

        for (int r = 0; r < 4; r++) begin
            run_test(16'($urandom_range(0, 65535)), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d: got 1 expected 0", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/or4_stim_seq_v.md
OR4_STIM_SEQ_V -- requirements
Module: or4_stim_seq_v

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1000, giving the number of clock cycles each input vector is held (legal range 2..65535).
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port i_rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port i_start, input, 1, the run request, sampled only in IDLE.
REQ-005 The block SHALL have port i_f, input, 1, the response from the downstream 4-input OR under test.
REQ-006 The block SHALL have ports o_a, o_b, o_c, o_d, output, 1 each, the stimulus bits (o_a = vector MSB, o_d = LSB).
REQ-007 The block SHALL have port o_busy, output, 1, high while a run is in progress.
REQ-008 The block SHALL have port o_done, output, 1, a one-cycle pulse at run completion.
REQ-009 The block SHALL have port o_err_cnt, output, 5, the mismatch count for the current/last run (0..16).
REQ-010 The block SHALL have port o_pass, output, 1, high when the last completed run had zero mismatches.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE; the reset state is IDLE.
REQ-012 IDLE SHALL drive o_a..o_d = 0000 and o_busy = 0.
REQ-013 IDLE with i_start = 1 at a rising edge SHALL go to RUN, with vector index = 0, hold counter = 0, o_err_cnt cleared and o_pass cleared in the same edge.
REQ-014 RUN SHALL drive {o_a,o_b,o_c,o_d} = vector index (0000..1111, ascending) with o_busy = 1.
REQ-015 The hold counter SHALL count 0..HOLD_CYCLES-1 per vector; i_f SHALL be sampled only on the edge where the counter equals HOLD_CYCLES-1.
REQ-016 Expected value SHALL be o_a|o_b|o_c|o_d of the current vector; sampled i_f different from expected SHALL increment o_err_cnt by 1.
REQ-017 After sampling, index SHALL increment and the counter SHALL return to 0; index 15 sampled SHALL go to DONE instead (no wrap to 0000 during a run).
REQ-018 Total RUN duration SHALL be exactly 16*HOLD_CYCLES cycles.
REQ-019 DONE SHALL last one cycle: o_done = 1, o_busy = 0, o_a..o_d = 0000, o_pass = (final o_err_cnt == 0); then go to IDLE.
REQ-020 o_err_cnt and o_pass SHALL hold their values in IDLE until the next accepted i_start.
REQ-021 i_start in RUN or DONE SHALL be ignored with no effect on timing or counts.
REQ-022 All outputs SHALL be registered; o_done SHALL never be high in two consecutive cycles.

Reset
REQ-023 i_rst_n = 0 SHALL immediately, without waiting for a clock edge, force IDLE, index 0, counter 0, o_a..o_d = 0000, o_busy = 0, o_done = 0, o_err_cnt = 0, o_pass = 0.
REQ-024 Reset mid-run SHALL abandon the run with no o_done pulse; a later i_start SHALL run all 16 vectors from 0000.

Structure
REQ-025 Shared package or4_seq_pkg SHALL hold the state encoding (IDLE/RUN/DONE), NUM_VECTORS = 16, VEC_W = 4 and ERR_W = 5.
REQ-026 The hold timer SHALL be one sub-module, or4_hold_timer_v (clear input, terminal-count output, HOLD_CYCLES parameter); everything else stays in the top.

Verification
REQ-027 HOLD_CYCLES = 4, i_f driven by a correct OR model, one i_start pulse -> o_busy high for 64 cycles, vectors 0000..1111 each held 4 cycles, o_done pulse, o_err_cnt = 0, o_pass = 1.
REQ-028 i_f stuck at 0 -> o_err_cnt = 15, o_pass = 0 at o_done.
REQ-029 i_f stuck at 1 -> o_err_cnt = 1 (vector 0000 only), o_pass = 0.
REQ-030 Extra i_start pulses at RUN cycle 10 and in the DONE cycle -> o_done at the same cycle as REQ-027, no second run, counts unchanged.
REQ-031 i_rst_n low while vector 0101 is applied -> all outputs 0 before the next edge, no o_done; a new i_start gives a full 64-cycle run from 0000.
REQ-032 Run with i_f stuck at 0 (err 15), then a correct run -> o_err_cnt reads 0 on the cycle after the second i_start, ends 0, o_pass = 1.
